// File: rtl/karatsuba_pkg.sv
// Shared definitions for the iterative Karatsuba multiplier: FSM encoding and
// the two's-complement magnitude helper used when capturing operands.
package karatsuba_pkg;

    // Widest operand the magnitude helper supports; callers truncate the result.
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HH   = 3'd1,
        LL   = 3'd2,
        MID  = 3'd3,
        FIN  = 3'd4
    } state_t;

    function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v,
                                                  input logic           negate);
        return negate ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/karatsuba_half_mult.sv
// Combinational H x H -> 2H unsigned multiplier; the only multiplier in the
// iterative Karatsuba datapath.
module karatsuba_half_mult #(
    parameter int H = 16
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    assign p = (2*H)'(a) * (2*H)'(b);

endmodule

// File: rtl/iterative_karatsuba_param.sv
// W x W -> 2W signed/unsigned multiplier built from one H x H multiplier,
// time-shared over the HH, LL and MID steps of a Karatsuba decomposition.
module iterative_karatsuba_param
    import karatsuba_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int H = W / 2;

    state_t         state;
    logic [W-1:0]   x, y;
    logic           neg;
    logic [W:0]     t;
    logic [2*W-1:0] p;

    logic [H-1:0]   xh, xl, yh, yl;
    logic [H:0]     xs, ys;
    logic [H-1:0]   ma, mb;
    logic [W-1:0]   m;
    logic [W+1:0]   mid, diff;
    logic [2*W-1:0] mid_term;

    assign xh = x[W-1:H];
    assign xl = x[H-1:0];
    assign yh = y[W-1:H];
    assign yl = y[H-1:0];
    assign xs = {1'b0, xh} + {1'b0, xl};
    assign ys = {1'b0, yh} + {1'b0, yl};

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (latch).
    always_comb begin
        ma = '0;
        mb = '0;
        case (state)
            HH:      begin ma = xh;          mb = yh;          end
            LL:      begin ma = xl;          mb = yl;          end
            MID:     begin ma = xs[H-1:0];   mb = ys[H-1:0];   end
            default: begin ma = '0;          mb = '0;          end
        endcase
    end

    karatsuba_half_mult #(.H(H)) u_mult (
        .a (ma),
        .b (mb),
        .p (m)
    );

    // Rebuild the full (Xh+Xl)*(Yh+Yl) from the H-bit product and the two carries.
    assign mid = ((W+2)'(xs[H] & ys[H]) << W)
               + (ys[H] ? ((W+2)'(xs[H-1:0]) << H) : '0)
               + (xs[H] ? ((W+2)'(ys[H-1:0]) << H) : '0)
               + (W+2)'(m);
    assign diff     = mid - (W+2)'(t);
    assign mid_term = (2*W)'(diff) << H;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            neg     <= 1'b0;
            t       <= '0;
            p       <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= W'(twos_mag(MAX_W'(a), is_signed & a[W-1]));
                        y     <= W'(twos_mag(MAX_W'(b), is_signed & b[W-1]));
                        neg   <= is_signed & (a[W-1] ^ b[W-1]);
                        busy  <= 1'b1;
                        state <= HH;
                    end
                end
                HH: begin
                    t     <= {1'b0, m};
                    p     <= {m, {W{1'b0}}};
                    state <= LL;
                end
                LL: begin
                    t     <= t + (W+1)'(m);
                    p     <= p + (2*W)'(m);
                    state <= MID;
                end
                MID: begin
                    p     <= p + mid_term;
                    state <= FIN;
                end
                FIN: begin
                    product <= neg ? (~p + (2*W)'(1)) : p;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_karatsuba_param.sv
// Scoreboard bench for iterative_karatsuba_param: a W=32 and a W=8 instance,
// directed corner cases plus randomised vectors against a plain-arithmetic model.
module tb_iterative_karatsuba_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, start32, sgn32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] prod32;

    logic        rst8, start8, sgn8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    iterative_karatsuba_param #(.W(32)) dut32 (
        .clk(clk), .rst(rst32), .start(start32), .is_signed(sgn32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32)
    );

    iterative_karatsuba_param #(.W(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    typedef struct {
        logic [63:0] p;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32_m, e8_m;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the mathematical product of the operands interpreted per mode.
    function automatic logic [63:0] ref32(input logic [31:0] av, input logic [31:0] bv, input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(av)) : longint'(av);
        sb = s ? longint'($signed(bv)) : longint'(bv);
        return 64'(sa * sb);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] av, input logic [7:0] bv, input logic s);
        int sa, sb;
        sa = s ? int'($signed(av)) : int'(av);
        sb = s ? int'($signed(bv)) : int'(bv);
        return 16'(sa * sb);
    endfunction

    // Monitors: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) check("w32_unexpected_done", 64'(done32), 64'd0);
            else begin
                e32_m = q32.pop_front();
                check("w32_product", prod32, e32_m.p);
                check("w32_latency", 64'(cyc), 64'(e32_m.due));
            end
        end
        if (done8) begin
            if (q8.size() == 0) check("w8_unexpected_done", 64'(done8), 64'd0);
            else begin
                e8_m = q8.pop_front();
                check("w8_product", 64'(prod8), e8_m.p);
                check("w8_latency", 64'(cyc), 64'(e8_m.due));
            end
        end
    end

    // One W=32 operation; optionally pokes start with other operands in HH, MID and FIN.
    task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic [63:0] exp_p, input bit poke);
        exp_t e;
        int   bcnt;
        @(negedge clk);
        a32 = av; b32 = bv; sgn32 = s; start32 = 1'b1;
        e.p = exp_p; e.due = cyc + 5;
        q32.push_back(e);
        bcnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (busy32) bcnt++;
            start32 = poke && (i != 2);
            if (poke) begin
                a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
            end
        end
        @(negedge clk);
        start32 = 1'b0;
        check("w32_busy_cycles", 64'(bcnt), 64'd4);
        check("w32_busy_done_cycle", 64'(busy32), 64'd0);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                       input logic [15:0] exp_p);
        exp_t e;
        @(negedge clk);
        a8 = av; b8 = bv; sgn8 = s; start8 = 1'b1;
        e.p = 64'(exp_p); e.due = cyc + 5;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rs;

        rst32 = 1'b1; start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        rst8  = 1'b1; start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        check("w32_reset_product", prod32, 64'd0);
        check("w32_reset_busy", 64'(busy32), 64'd0);
        check("w32_reset_done", 64'(done32), 64'd0);
        check("w8_reset_product", 64'(prod8), 64'd0);
        check("w8_reset_busy", 64'(busy8), 64'd0);
        check("w8_reset_done", 64'(done8), 64'd0);

        fork
            begin
                op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
                op32(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
                op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
                op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 1'b0);
                repeat (3) @(negedge clk);
                check("w32_product_hold", prod32, 64'h0B00_EA4E_242D_2080);

                op32(32'h0001_2345, 32'h0006_789A, 1'b0,
                     ref32(32'h0001_2345, 32'h0006_789A, 1'b0), 1'b1);
                check("w32_product_after_ignored_starts", prod32,
                      ref32(32'h0001_2345, 32'h0006_789A, 1'b0));

                // Abort an operation with reset at its LL edge.
                @(negedge clk);
                a32 = 32'hDEAD_BEEF; b32 = 32'd3; sgn32 = 1'b0; start32 = 1'b1;
                @(negedge clk);
                start32 = 1'b0;
                @(negedge clk);
                rst32 = 1'b1;
                @(negedge clk);
                rst32 = 1'b0;
                check("w32_abort_product", prod32, 64'd0);
                check("w32_abort_busy", 64'(busy32), 64'd0);
                check("w32_abort_done", 64'(done32), 64'd0);
                op32(32'd7, 32'd6, 1'b0, 64'd42, 1'b0);

                for (int i = 0; i < 2000; i++) begin
                    ra = $urandom; rb = $urandom; rs = 1'($urandom);
                    op32(ra, rb, rs, ref32(ra, rb, rs), 1'b0);
                end
            end
            begin
                op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
                op8(8'h80, 8'h7F, 1'b1, 16'hC080);
                for (int i = 0; i < 8000; i++) begin
                    ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom);
                    op8(ra8, rb8, rs, ref8(ra8, rb8, rs));
                end
            end
        join

        repeat (4) @(negedge clk);
        check("w32_outstanding_results", 64'(q32.size()), 64'd0);
        check("w8_outstanding_results", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
